// File: rtl/shiftin_pkg.sv
// Shared definitions for the shiftin_chain console pad emulator:
// channel limit, default fill level and counter-width helper.
package shiftin_pkg;

  localparam int unsigned MAX_CHANNELS = 4;
  localparam logic        FILL_DEFAULT = 1'b1;

  // Ceiling log2; 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Width of a counter that must hold values 0..max_value, at least 1 bit.
  function automatic int unsigned cnt_width(input int unsigned max_value);
    int unsigned w;
    w = clog2(max_value + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/pad_sync_edge.sv
// Synchronises one asynchronous console pad line into system_clock and
// derives its level plus one-cycle rise/fall indications.
// Optional glitch filter enabled by defining SHIFTIN_GLITCH_FILTER_EN.
module pad_sync_edge
  import shiftin_pkg::*;
#(
  parameter int unsigned GLITCH_CYCLES = 3
) (
  input  logic system_clock,
  input  logic reset_n,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       filt;
  logic       dly;

  // Two-flop synchroniser for the asynchronous pad input.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[0], pad};
  end

`ifdef SHIFTIN_GLITCH_FILTER_EN
  localparam int unsigned GW = cnt_width(GLITCH_CYCLES);

  logic [GW-1:0] stable_cnt;

  // Accept a new level only after GLITCH_CYCLES consecutive differing samples.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      filt       <= 1'b0;
      stable_cnt <= '0;
    end else if (sync[1] == filt) begin
      stable_cnt <= '0;
    end else if (stable_cnt == GW'(GLITCH_CYCLES - 1)) begin
      filt       <= sync[1];
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + GW'(1);
    end
  end
`else
  localparam int unsigned unused_glitch_cycles = GLITCH_CYCLES;

  // Without the filter the synchronised level is used directly.
  always_comb filt = sync[1];
`endif

  // Delay flop for edge detection.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) dly <= 1'b0;
    else          dly <= filt;
  end

  // Level and edge indications.
  always_comb begin
    level = filt;
    rise  = filt & ~dly;
    fall  = ~filt & dly;
  end

endmodule

// File: rtl/shiftin_chain.sv
// Multi-channel parallel-in/serial-out console pad emulator. Latch
// snapshots the button words; console clock rises shift, falls update data.
// Optional pad glitch filter: define SHIFTIN_GLITCH_FILTER_EN.
module shiftin_chain
  import shiftin_pkg::*;
#(
  parameter int unsigned BITS          = 16,
  parameter int unsigned CHANNELS      = 2,
  parameter bit          LSB_FIRST     = 1'b0,
  parameter logic        FILL          = FILL_DEFAULT,
  parameter int unsigned GLITCH_CYCLES = 3
) (
  input  logic                     system_clock,
  input  logic                     reset_n,
  input  logic                     clk,
  input  logic                     latch,
  input  logic [CHANNELS*BITS-1:0] i,
  output logic [CHANNELS-1:0]      data,
  output logic                     latch_pulse,
  output logic                     frame_done
);

  localparam int unsigned CW      = cnt_width(BITS);
  localparam int unsigned OUT_IDX = LSB_FIRST ? 0 : BITS - 1;

  logic            clk_s, clk_rise, clk_fall;
  logic            latch_s, latch_rise, latch_fall;
  logic            unused_edges;
  logic [BITS-1:0] sr [CHANNELS];
  logic [CW-1:0]   cnt;

  pad_sync_edge #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_clk_sync (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .pad          (clk),
    .level        (clk_s),
    .rise         (clk_rise),
    .fall         (clk_fall)
  );

  pad_sync_edge #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_latch_sync (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .pad          (latch),
    .level        (latch_s),
    .rise         (latch_rise),
    .fall         (latch_fall)
  );

  assign unused_edges = clk_s ^ latch_fall;

  // One shift step toward the output end, FILL entering the vacated end.
  function automatic logic [BITS-1:0] shift_one(input logic [BITS-1:0] v);
    if (LSB_FIRST) return {FILL, v[BITS-1:1]};
    else           return {v[BITS-2:0], FILL};
  endfunction

  // Load while latched; otherwise shift on clock rise, present on clock fall.
  // A load in the same cycle as a clock rise wins because latch_s gates all
  // clock handling, so the coincident rise is simply dropped.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++) sr[c] <= {BITS{FILL}};
      cnt         <= '0;
      data        <= {CHANNELS{FILL}};
      latch_pulse <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      latch_pulse <= latch_rise;
      frame_done  <= 1'b0;
      if (latch_s) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          sr[c]   <= i[c*BITS +: BITS];
          data[c] <= i[c*BITS + OUT_IDX];
        end
        cnt <= '0;
      end else begin
        if (clk_rise && (cnt < CW'(BITS))) begin
          for (int unsigned c = 0; c < CHANNELS; c++) sr[c] <= shift_one(sr[c]);
          cnt        <= cnt + CW'(1);
          frame_done <= (cnt == CW'(BITS - 1));
        end
        if (clk_fall) begin
          for (int unsigned c = 0; c < CHANNELS; c++) data[c] <= sr[c][OUT_IDX];
        end
      end
    end
  end

endmodule

// File: doc/shiftin_chain.md
# shiftin_chain

Multi-channel, parametrised successor to the single-line console shift register. It emulates the parallel-in/serial-out pad protocol used by NES/SNES-style ports, one data line per channel: latch snapshots the USB-side button words, and console clock pulses serialise them. All console inputs are synchronised and edge-detected in the `system_clock` domain, so no logic is clocked by pad signals. The block sits between the USB report decoder, which drives `i`, and the console port pins.

## Interface
Parameters:
- `BITS`, 16: bits per channel per frame (≥2).
- `CHANNELS`, 2: independent data lines (multitap / dual-data pads), 1–4.
- `LSB_FIRST`, 0: 0 shifts bit `BITS-1` first; 1 shifts bit 0 first.
- `FILL`, 1'b1: level driven after all `BITS` bits are clocked out, and in reset.
- `GLITCH_CYCLES`, 3: stability window in `system_clock` cycles. Used only when the filter macro is defined.

Ports:
- `system_clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `clk`  in  1  console pad clock, asynchronous.
- `latch`  in  1  console pad latch, asynchronous, active-high.
- `i`  in  CHANNELS*BITS  button words. Channel c occupies `i[c*BITS +: BITS]`.
- `data`  out  CHANNELS  serial data to console, one bit per channel.
- `latch_pulse`  out  1  one-cycle strobe when a snapshot is taken.
- `frame_done`  out  1  one-cycle strobe when bit `BITS` of a frame has been shifted.

## Operation
- Each of `clk` and `latch` passes through a 2-flop synchroniser, then a delay flop for edge detection. This yields `clk_s`, `clk_rise`, `clk_fall`, `latch_s` and `latch_rise`.
- Per channel there is one `BITS`-wide shift register `sr[c]`, plus a shared bit counter `cnt` (width clog2(BITS+1)).
- Load: on every cycle that `latch_s` is 1:
  - `sr[c] <= i` slice;
  - `cnt <= 0`;
  - `data[c] <=` first bit, which is MSB, or LSB if `LSB_FIRST`.
- Clock edges are ignored while `latch_s` is 1.
- `latch_pulse` is 1 for exactly the one cycle in which `latch_rise` is detected.
- Shift: on `clk_rise` with `latch_s` 0 and `cnt < BITS`:
  - each `sr[c]` shifts toward the output end, with `FILL` inserted at the vacated end;
  - `cnt` increments.
- Output update: on `clk_fall` with `latch_s` 0, `data[c] <=` the output-end bit of `sr[c]`.
- When `cnt` reaches `BITS`:
  - `frame_done` pulses for one cycle, on the cycle the increment to `BITS` is registered;
  - `cnt` saturates at `BITS`;
  - further clocks keep `data` at `FILL` and produce no more `frame_done` pulses.
- Simultaneous `latch_rise` and `clk_rise`: the load wins, no shift occurs, and `cnt` = 0.
- A latch asserted mid-frame aborts the frame, and the new snapshot is loaded.
- Reset (async, `reset_n` = 0):
  - `sr` = all `FILL`, `cnt` = 0, `data` = all `FILL`;
  - `latch_pulse` = 0, `frame_done` = 0;
  - synchroniser and delay flops = 0.
- A reset mid-frame drives `data` to `FILL` immediately. After release, the block waits for a new latch.

## Timing
- Pad edge to internal edge detection: 2 synchroniser cycles, plus 1 for the delay flop. Registered effects (`sr`, `cnt`, `data`, strobes) are visible on the 3rd `system_clock` rising edge after the edge is first sampled.
- `data` during latch-high tracks changes on `i` with 1 cycle of latency. Upstream should hold `i` stable around the latch.
- Minimum pad clock high/low time: 3 `system_clock` cycles (filter off), or 3+`GLITCH_CYCLES` (filter on).
- The strobes are combinationally free: they are driven from flops and are never asserted together.

## Configuration
- `SHIFTIN_GLITCH_FILTER_EN` defined:
  - after the synchroniser, each of `clk` and `latch` changes its filtered level only after `GLITCH_CYCLES` consecutive identical samples;
  - shorter pulses are discarded;
  - latency grows by `GLITCH_CYCLES` cycles.
- Not defined: filter logic is absent, `GLITCH_CYCLES` is ignored, and latency is exactly as stated in Timing.

## Structure
- Shared package `shiftin_pkg`:
  - `CLOG2` helper / counter-width function;
  - `MAX_CHANNELS` = 4;
  - the `FILL` default constant.
- Sub-module `pad_sync_edge`: synchroniser, optional glitch filter, delay flop, and rise/fall outputs. It is instanced twice, once for `clk` and once for `latch`.

## Test plan
- Reset, then drive `latch` high with channel 0 `i` = 16'hA5C3, channel 1 `i` = 16'h0001 (MSB-first). Expect `data` = 2'b01 after 3 cycles, and one `latch_pulse`.
- Apply 16 clock pulses (8 cycles high / 8 cycles low). Expect channel 0 to serialise 1010_0101_1100_0011 and channel 1 to serialise fifteen 0s then 1. Expect `frame_done` exactly once, at the 16th rise.
- Apply 4 extra clocks after the frame. Expect `data` to stay 2'b11, with no `frame_done`.
- With `LSB_FIRST`=1 and `i` = 16'h8001, expect the bit order 1, then fourteen 0s, then 1.
- Pulse `latch` at the same cycle as a `clk` rise after bit 5. Expect a reload, `data` = first bit of the new word, and the next frame_done only after 16 more clocks.
- Assert `reset_n` low mid-frame, then release. Expect `data` = 2'b11 immediately and no shifting until the next latch.
- With `SHIFTIN_GLITCH_FILTER_EN` defined, send a 2-cycle `clk` glitch (`GLITCH_CYCLES`=3). Expect no shift; a 5-cycle pulse shifts one bit.
